seg7_pattern_reader: RTL and testbench

- Reverse path of the 0–F hex-to-seven-segment decoder.
- Watches a 7-bit active-low segment bus and waits until the pattern is stable.
- Converts each newly stable pattern back to its 4-bit hex digit and delivers it on a valid/ready handshake.
- Used by loopback self-test benches and by the lab board monitor to read back what a HEX display is showing.

---
 rtl/seg7_pattern_reader_if.sv | 19 +
 rtl/seg7_pattern_reader.sv | 74 +++++++
 tb/tb_seg7_pattern_reader.sv | 116 +++++++++++
 3 files changed

// File: rtl/seg7_pattern_reader_if.sv
// seg7_pattern_reader_if: segment bus in, decoded digit handshake and status out
interface seg7_pattern_reader_if;
  logic [6:0] seg_in;
  logic       digit_ready;
  logic [3:0] digit;
  logic       digit_valid;
  logic       blank;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       overrun;
  modport master (
    output seg_in, digit_ready,
    input  digit, digit_valid, blank, err_pulse, err_count, overrun
  );
  modport slave (
    input  seg_in, digit_ready,
    output digit, digit_valid, blank, err_pulse, err_count, overrun
  );
endinterface

// File: rtl/seg7_pattern_reader.sv
// seg7_pattern_reader: debounces an active-low 7-segment bus and decodes stable glyphs to hex digits
module seg7_pattern_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  seg7_pattern_reader_if.slave bus
);
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  typedef enum logic {IDLE, PEND} state_t;
  state_t state_q, state_d;
  logic [6:0] sample_q, sample_d, last_q, last_d;
  logic [7:0] cnt_q, cnt_d, err_count_q, err_count_d;
  logic [3:0] digit_q, digit_d, val;
  logic blank_q, blank_d, err_q, err_d, overrun_q, overrun_d;
  logic legal, accept, load, xfer, bad;
  always_comb begin
    legal = 1'b0;
    val = 4'd0;
    for (int i = 0; i < 16; i++)
      if (sample_q == GLYPHS[i]) begin
        legal = 1'b1;
        val = 4'(i);
      end
    sample_d = bus.seg_in;
    cnt_d = (bus.seg_in != sample_q) ? 8'd1 : (cnt_q == STABLE ? cnt_q : cnt_q + 8'd1);
    // a pattern is reported once; returning to the last reported one after a short glitch is silent
    accept = (cnt_q == STABLE) && (sample_q != last_q);
    last_d = accept ? sample_q : last_q;
    load = accept && legal;
    xfer = (state_q == PEND) && bus.digit_ready;
    bad = accept && !legal && (sample_q != BLANK);
    state_d = load ? PEND : (xfer ? IDLE : state_q);
    digit_d = load ? val : digit_q;
    overrun_d = overrun_q | (load && (state_q == PEND) && !bus.digit_ready);
    blank_d = accept ? (sample_q == BLANK) : blank_q;
    err_d = bad;
    err_count_d = (bad && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sample_q <= BLANK;
      cnt_q <= STABLE;
      last_q <= BLANK;
      digit_q <= 4'd0;
      blank_q <= 1'b1;
      err_q <= 1'b0;
      err_count_q <= 8'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sample_q <= sample_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      digit_q <= digit_d;
      blank_q <= blank_d;
      err_q <= err_d;
      err_count_q <= err_count_d;
      overrun_q <= overrun_d;
    end
  end
  assign bus.digit = digit_q;
  assign bus.digit_valid = (state_q == PEND);
  assign bus.blank = blank_q;
  assign bus.err_pulse = err_q;
  assign bus.err_count = err_count_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_seg7_pattern_reader.sv
// tb_seg7_pattern_reader: directed stimulus with a digit scoreboard checked on every transfer
module tb_seg7_pattern_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int transfers = 0;
  int pulses = 0;
  logic [3:0] exp_q[$];
  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  seg7_pattern_reader_if bus();
  seg7_pattern_reader #(.STABLE_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input logic [6:0] p, input int n);
    bus.seg_in = p;
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!reset && bus.err_pulse) pulses++;
    if (!reset && bus.digit_valid && bus.digit_ready) begin
      transfers++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_digit: got %0h expected none", bus.digit);
      end else chk("digit", int'(bus.digit), int'(exp_q.pop_front()));
    end
  end
  initial begin
    bus.seg_in = 7'h7F;
    bus.digit_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(bus.digit_valid), 0);
    chk("rst_blank", int'(bus.blank), 1);
    chk("rst_errc", int'(bus.err_count), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    reset = 1'b0;
    drive(7'h7F, 20);
    chk("idle_valid", int'(bus.digit_valid), 0);
    chk("idle_blank", int'(bus.blank), 1);
    chk("idle_pulses", pulses, 0);
    exp_q.push_back(4'h2);
    bus.seg_in = 7'h24;
    repeat (4) @(posedge clk);
    #1;
    chk("lat_early", int'(bus.digit_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_valid", int'(bus.digit_valid), 1);
    chk("lat_digit", int'(bus.digit), 2);
    chk("lat_blank", int'(bus.blank), 0);
    @(posedge clk);
    #1;
    chk("one_cycle", int'(bus.digit_valid), 0);
    drive(7'h24, 10);
    chk("no_rereport", transfers, 1);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(4'(i));
      drive(glyph_tab[i], 6);
    end
    chk("sweep_xfers", transfers, 17);
    chk("sweep_errc", int'(bus.err_count), 0);
    exp_q.push_back(4'h0);
    drive(7'h40, 6);
    drive(7'h79, 3);
    drive(7'h40, 6);
    chk("glitch_xfers", transfers, 18);
    drive(7'h55, 6);
    chk("err_pulses", pulses, 1);
    chk("err_count", int'(bus.err_count), 1);
    chk("err_valid", int'(bus.digit_valid), 0);
    chk("err_blank", int'(bus.blank), 0);
    drive(7'h7F, 6);
    chk("blank_back", int'(bus.blank), 1);
    chk("blank_valid", int'(bus.digit_valid), 0);
    bus.digit_ready = 1'b0;
    drive(7'h30, 6);
    chk("pend_valid", int'(bus.digit_valid), 1);
    chk("pend_digit", int'(bus.digit), 3);
    chk("pend_overrun", int'(bus.overrun), 0);
    exp_q.push_back(4'h4);
    drive(7'h19, 6);
    chk("ovr_valid", int'(bus.digit_valid), 1);
    chk("ovr_digit", int'(bus.digit), 4);
    chk("ovr_flag", int'(bus.overrun), 1);
    bus.digit_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.digit_ready = 1'b0;
    chk("ovr_xfers", transfers, 19);
    chk("ovr_cleared", int'(bus.digit_valid), 0);
    chk("ovr_sticky", int'(bus.overrun), 1);
    drive(7'h30, 6);
    chk("drop_pend", int'(bus.digit_valid), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_valid", int'(bus.digit_valid), 0);
    chk("rst2_overrun", int'(bus.overrun), 0);
    chk("rst2_blank", int'(bus.blank), 1);
    chk("rst2_errc", int'(bus.err_count), 0);
    chk("queue_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
